// File: rtl/demux_gate_alu.sv
// Registered universal-gate unit: every bitwise function is a per-bit network of
// 1:2 demux cells, results queue in a DEPTH-entry FIFO behind valid/ready handshakes.

module two_one_demux (
  input  logic din,
  input  logic sel,
  output logic y0,
  output logic y1
);
  assign y0 = din & ~sel;
  assign y1 = din & sel;
endmodule

module demux_gate_alu #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       y_op,
  output logic             err,
  output logic [15:0]      ops_done
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic             err;
    logic [2:0]       op;
    logic [WIDTH-1:0] y;
  } entry_t;

  logic [WIDTH-1:0] g_and, g_nand, g_or, g_nor, g_xor, g_xnor, g_nota;

  // Per-bit gate network; inverters are demuxes with din tied high (y0 = ~sel, y1 = sel)
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    logic na, p, q, and_raw, nor_raw, np, xnor_raw;
    logic unused_a, unused_p, unused_q;

    two_one_demux u_inv_a (.din(1'b1),   .sel(a[i]),     .y0(na),        .y1(unused_a));
    two_one_demux u_and   (.din(a[i]),   .sel(b[i]),     .y0(p),         .y1(and_raw));
    two_one_demux u_nor   (.din(na),     .sel(b[i]),     .y0(nor_raw),   .y1(q));
    two_one_demux u_nand  (.din(1'b1),   .sel(and_raw),  .y0(g_nand[i]), .y1(g_and[i]));
    two_one_demux u_or    (.din(1'b1),   .sel(nor_raw),  .y0(g_or[i]),   .y1(g_nor[i]));
    two_one_demux u_inv_p (.din(1'b1),   .sel(p),        .y0(np),        .y1(unused_p));
    two_one_demux u_xnor  (.din(np),     .sel(q),        .y0(xnor_raw),  .y1(unused_q));
    two_one_demux u_xor   (.din(1'b1),   .sel(xnor_raw), .y0(g_xor[i]),  .y1(g_xnor[i]));

    assign g_nota[i] = na;
  end

  entry_t din_c;

  // Function select; op 111 is illegal and stores a zero result flagged with err
  always_comb begin
    din_c     = '0;
    din_c.op  = op;
    din_c.err = 1'b0;
    case (op)
      3'd0:    din_c.y = g_and;
      3'd1:    din_c.y = g_nand;
      3'd2:    din_c.y = g_or;
      3'd3:    din_c.y = g_nor;
      3'd4:    din_c.y = g_xor;
      3'd5:    din_c.y = g_xnor;
      3'd6:    din_c.y = g_nota;
      default: begin
        din_c.y   = '0;
        din_c.err = 1'b1;
      end
    endcase
  end

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [CNT_W-1:0] count, count_nxt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic             push_c, pop_c;

  assign in_ready  = rst_n & (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign y         = head.y;
  assign y_op      = head.op;
  assign err       = head.err;

  always_comb begin
    push_c     = in_valid & in_ready;
    pop_c      = out_valid & out_ready;
    count_nxt  = count + CNT_W'(push_c) - CNT_W'(pop_c);
    rd_ptr_nxt = rd_ptr + PTR_W'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= din_c;
  end

  // Head register lets y/y_op/err hold their last value once the FIFO drains
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      head     <= '0;
      ops_done <= '0;
    end else begin
      count  <= count_nxt;
      wr_ptr <= wr_ptr + PTR_W'(push_c);
      rd_ptr <= rd_ptr_nxt;
      if (pop_c) ops_done <= ops_done + 16'd1;
      // A new head equal to the write slot can only be the entry written this edge
      if (count_nxt != '0) begin
        if (push_c && (rd_ptr_nxt == wr_ptr)) head <= din_c;
        else                                   head <= mem[rd_ptr_nxt];
      end
    end
  end

endmodule
